// File: rtl/mips8_pkg.sv
`default_nettype none
// ============================================================================
// mips8_pkg : state encoding, stage-strobe constants and PC width shared by
//             the pc_sequencer block.
// Rev 1.0
// ============================================================================
package mips8_pkg;

    localparam int C_PC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Strobe vector ordering: {wb, mem, ex, id, if}
    localparam logic [4:0] C_STB_NONE = 5'b00000;
    localparam logic [4:0] C_STB_IF   = 5'b00001;
    localparam logic [4:0] C_STB_ID   = 5'b00010;
    localparam logic [4:0] C_STB_EX   = 5'b00100;
    localparam logic [4:0] C_STB_MEM  = 5'b01000;
    localparam logic [4:0] C_STB_WB   = 5'b10000;

    function automatic logic [4:0] stage_strobes(input state_e s);
        logic [4:0] r;
        case (s)
            ST_FETCH:  r = C_STB_IF;
            ST_DECODE: r = C_STB_ID;
            ST_EXEC:   r = C_STB_EX;
            ST_MEM:    r = C_STB_MEM;
            ST_WB:     r = C_STB_WB;
            default:   r = C_STB_NONE;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// next_pc_calc : combinational next-PC selection (jump > taken branch > +1).
// Rev 1.0
// ============================================================================
module next_pc_calc
    import mips8_pkg::*;
(
    input  logic [C_PC_W-1:0] pc_i,
    input  logic              jump_i,
    input  logic              branch_taken_i,
    input  logic [C_PC_W-1:0] jump_target_i,
    input  logic [4:0]        branch_offset_i,
    output logic [C_PC_W-1:0] next_pc_o
);

    logic [C_PC_W-1:0] w_pc_inc;
    logic [C_PC_W-1:0] w_offset_sext;

    assign w_pc_inc      = pc_i + {{(C_PC_W-1){1'b0}}, 1'b1};
    assign w_offset_sext = {{(C_PC_W-5){branch_offset_i[4]}}, branch_offset_i};

    // Arithmetic is naturally modulo 2^C_PC_W, giving the required wrap.
    always_comb begin
        next_pc_o = w_pc_inc;
        if (jump_i) begin
            next_pc_o = jump_target_i;
        end else if (branch_taken_i) begin
            next_pc_o = w_pc_inc + w_offset_sext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with PC update,
//                MEM wait timeout, halt/restart and retired-instruction count.
// Rev 1.0
// ============================================================================
module pc_sequencer
    import mips8_pkg::*;
#(
    parameter logic [C_PC_W-1:0] RESET_PC    = 8'h00,
    parameter logic [3:0]        MEM_TIMEOUT = 4'd15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic              zero_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              regwrite_i,
    input  logic              halt_instr_i,
    input  logic [C_PC_W-1:0] jump_target_i,
    input  logic [4:0]        branch_offset_i,
    input  logic              mem_ready_i,
    output logic [C_PC_W-1:0] pc_o,
    output logic              if_en_o,
    output logic              id_en_o,
    output logic              ex_en_o,
    output logic              mem_en_o,
    output logic              wb_en_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              mem_timeout_o,
    output logic [7:0]        instr_count_o
);

    localparam logic [3:0] C_WAIT_LAST = MEM_TIMEOUT - 4'd1;

    state_e            state_q, state_d;
    logic [C_PC_W-1:0] pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        wait_q, wait_d;
    logic              btaken_q, btaken_d;
    logic              timeout_q, timeout_d;
    logic [C_PC_W-1:0] w_next_pc;
    logic [4:0]        w_stb;

    next_pc_calc u_next_pc_calc (
        .pc_i            (pc_q),
        .jump_i          (jump_i),
        .branch_taken_i  (btaken_q),
        .jump_target_i   (jump_target_i),
        .branch_offset_i (branch_offset_i),
        .next_pc_o       (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= 8'h00;
            wait_q    <= 4'd0;
            btaken_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            btaken_q  <= btaken_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        btaken_d  = btaken_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = halt_instr_i ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                btaken_d = branch_i & zero_i;
                wait_d   = 4'd0;
                state_d  = (memread_i | memwrite_i) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                // wait_q counts MEM cycles already spent without mem_ready.
                if (mem_ready_i) begin
                    wait_d  = 4'd0;
                    state_d = ST_WB;
                end else if (wait_q == C_WAIT_LAST) begin
                    wait_d    = 4'd0;
                    timeout_d = 1'b1;
                    state_d   = ST_WB;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_WB: begin
                pc_d    = w_next_pc;
                cnt_d   = cnt_q + 8'd1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                if (start_i) begin
                    pc_d      = RESET_PC;
                    timeout_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from state so reset clears them immediately.
    assign w_stb         = stage_strobes(state_q);
    assign if_en_o       = w_stb[0];
    assign id_en_o       = w_stb[1];
    assign ex_en_o       = w_stb[2];
    assign mem_en_o      = w_stb[3];
    assign wb_en_o       = w_stb[4] & regwrite_i;
    assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted_o      = (state_q == ST_HALT);
    assign pc_o          = pc_q;
    assign mem_timeout_o = timeout_q;
    assign instr_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed instruction stream against an instruction-level
//                   model of the sequencer, plus hand-computed pins.
// Rev 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam int         TB_TIMEOUT = 15;
    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_IF   = 5'b00001;
    localparam logic [4:0] E_ID   = 5'b00010;
    localparam logic [4:0] E_EX   = 5'b00100;
    localparam logic [4:0] E_MEM  = 5'b01000;
    localparam logic [4:0] E_WB   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i = 1'b0, jump_i = 1'b0, branch_i = 1'b0, zero_i = 1'b0;
    logic       memread_i = 1'b0, memwrite_i = 1'b0, regwrite_i = 1'b0;
    logic       halt_instr_i = 1'b0, mem_ready_i = 1'b0;
    logic [7:0] jump_target_i = 8'h00;
    logic [4:0] branch_offset_i = 5'd0;
    logic [7:0] pc_o, instr_count_o;
    logic       if_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o;
    logic       busy_o, halted_o, mem_timeout_o;

    pc_sequencer #(.RESET_PC(8'h00), .MEM_TIMEOUT(4'd15)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .jump_i          (jump_i),
        .branch_i        (branch_i),
        .zero_i          (zero_i),
        .memread_i       (memread_i),
        .memwrite_i      (memwrite_i),
        .regwrite_i      (regwrite_i),
        .halt_instr_i    (halt_instr_i),
        .jump_target_i   (jump_target_i),
        .branch_offset_i (branch_offset_i),
        .mem_ready_i     (mem_ready_i),
        .pc_o            (pc_o),
        .if_en_o         (if_en_o),
        .id_en_o         (id_en_o),
        .ex_en_o         (ex_en_o),
        .mem_en_o        (mem_en_o),
        .wb_en_o         (wb_en_o),
        .busy_o          (busy_o),
        .halted_o        (halted_o),
        .mem_timeout_o   (mem_timeout_o),
        .instr_count_o   (instr_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_cycles = 0;
    int c0;
    logic chk_en = 1'b0;

    // Model: expected architectural state and current stage.
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    logic       m_to = 1'b0;
    logic [4:0] m_stb = E_NONE;
    logic       m_busy = 1'b0;
    logic       m_halted = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_en_o) mem_cycles++;
        if (chk_en) begin
            check("pc", int'(pc_o), int'(m_pc));
            check("instr_count", int'(instr_count_o), int'(m_cnt));
            check("strobes", int'({wb_en_o, mem_en_o, ex_en_o, id_en_o, if_en_o}), int'(m_stb));
            check("busy", int'(busy_o), int'(m_busy));
            check("halted", int'(halted_o), int'(m_halted));
            check("mem_timeout", int'(mem_timeout_o), int'(m_to));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stage(input logic [4:0] stb, input logic busy, input logic halted);
        m_stb = stb;
        m_busy = busy;
        m_halted = halted;
    endtask

    task automatic clear_inputs();
        jump_i = 0; branch_i = 0; zero_i = 0; memread_i = 0; memwrite_i = 0;
        regwrite_i = 0; halt_instr_i = 0; mem_ready_i = 0; start_i = 0;
        jump_target_i = 8'h00; branch_offset_i = 5'd0;
    endtask

    // Entered with the DUT in FETCH; returns in the next FETCH, in HALT, or in reset.
    task automatic run_instr(input logic j, input logic b, input logic z,
                             input logic mr, input logic mw, input logic rw,
                             input logic h, input logic [7:0] tgt,
                             input logic [4:0] off, input int ready_at,
                             input int abort_at);
        logic [7:0] nxt;
        logic       tmo;
        tmo = 1'b0;
        jump_i = j; branch_i = b; zero_i = z; memread_i = mr; memwrite_i = mw;
        regwrite_i = rw; halt_instr_i = h; jump_target_i = tgt; branch_offset_i = off;
        mem_cycles = 0;
        tick(); set_stage(E_ID, 1, 0);
        if (h) begin
            tick(); set_stage(E_NONE, 0, 1);
            clear_inputs();
            return;
        end
        tick(); set_stage(E_EX, 1, 0);
        if (mr || mw) begin
            for (int i = 0; i < TB_TIMEOUT; i++) begin
                tick(); set_stage(E_MEM, 1, 0);
                mem_ready_i = (i == ready_at);
                if (i == abort_at) begin
                    #2;
                    rst_n = 1'b0;
                    clear_inputs();
                    m_pc = 8'h00; m_cnt = 8'h00; m_to = 1'b0;
                    set_stage(E_NONE, 0, 0);
                    #1;
                    check("abort_pc", int'(pc_o), 0);
                    check("abort_count", int'(instr_count_o), 0);
                    check("abort_busy", int'(busy_o), 0);
                    check("abort_mem_en", int'(mem_en_o), 0);
                    return;
                end
                if (i == ready_at) break;
                if (i == TB_TIMEOUT - 1) tmo = 1'b1;
            end
        end
        tick(); mem_ready_i = 1'b0;
        if (tmo) m_to = 1'b1;
        set_stage(rw ? E_WB : E_NONE, 1, 0);
        if (j)           nxt = tgt;
        else if (b && z) nxt = m_pc + 8'd1 + {{3{off[4]}}, off};
        else             nxt = m_pc + 8'd1;
        tick();
        m_pc = nxt;
        m_cnt = m_cnt + 8'd1;
        set_stage(E_IF, 1, 0);
        clear_inputs();
    endtask

    task automatic plain();
        run_instr(0, 0, 0, 0, 0, 1, 0, 8'h00, 5'd0, -1, -1);
    endtask

    task automatic jump_to(input logic [7:0] t);
        run_instr(1, 0, 0, 0, 0, 0, 0, t, 5'd0, -1, -1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_pc", int'(pc_o), 0);
        check("rst_count", int'(instr_count_o), 0);
        check("rst_busy", int'(busy_o), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_release", int'(busy_o), 0);

        start_i = 1'b1;
        tick(); set_stage(E_IF, 1, 0);
        start_i = 1'b0;
        c0 = cyc;
        check("fetch_pc0", int'(pc_o), 8'h00);
        plain(); check("fetch_pc1", int'(pc_o), 8'h01);
        plain(); check("fetch_pc2", int'(pc_o), 8'h02);
        plain(); check("fetch_pc3", int'(pc_o), 8'h03);
        check("count3", int'(instr_count_o), 3);
        check("cycles12", cyc - c0, 12);

        plain(); plain();
        check("pc05", int'(pc_o), 8'h05);
        run_instr(0, 1, 1, 0, 0, 1, 0, 8'h00, 5'b00011, -1, -1);
        check("branch_taken_pc", int'(pc_o), 8'h09);
        jump_to(8'h05);
        run_instr(0, 1, 0, 0, 0, 1, 0, 8'h00, 5'b00011, -1, -1);
        check("branch_not_taken_pc", int'(pc_o), 8'h06);
        run_instr(1, 1, 1, 0, 0, 1, 0, 8'h40, 5'b00011, -1, -1);
        check("jump_wins_pc", int'(pc_o), 8'h40);

        run_instr(0, 0, 0, 1, 0, 1, 0, 8'h00, 5'd0, 3, -1);
        check("mem_4_cycles", mem_cycles, 4);
        run_instr(0, 0, 0, 0, 1, 0, 0, 8'h00, 5'd0, 0, -1);
        check("mem_1_cycle", mem_cycles, 1);
        check("pc42", int'(pc_o), 8'h42);

        jump_to(8'hFF);
        plain();
        check("wrap_seq", int'(pc_o), 8'h00);
        plain();
        run_instr(0, 1, 1, 0, 0, 1, 0, 8'h00, 5'b11100, -1, -1);
        check("wrap_branch", int'(pc_o), 8'hFE);

        run_instr(0, 0, 0, 1, 0, 1, 0, 8'h00, 5'd0, -1, -1);
        check("timeout_cycles", mem_cycles, 15);
        check("timeout_flag", int'(mem_timeout_o), 1);
        plain();
        check("timeout_sticky", int'(mem_timeout_o), 1);

        jump_to(8'h07);
        run_instr(0, 0, 0, 0, 0, 0, 1, 8'h00, 5'd0, -1, -1);
        check("halt_flag", int'(halted_o), 1);
        check("halt_pc", int'(pc_o), 8'h07);
        tick();
        check("halt_stays", int'(halted_o), 1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_pc = 8'h00; m_to = 1'b0;
        set_stage(E_IF, 1, 0);
        check("restart_pc", int'(pc_o), 8'h00);
        check("restart_to", int'(mem_timeout_o), 0);
        check("count_kept", int'(instr_count_o), 18);

        plain();
        run_instr(0, 0, 0, 1, 0, 1, 0, 8'h00, 5'd0, -1, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_abort", int'(busy_o), 0);
        check("pc_after_abort", int'(pc_o), 8'h00);
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
